// File: rtl/capture_sram_arb_pkg.sv
// Shared types and default sizing for the capture/MCU SRAM arbiter.
package capture_sram_pkg;

  // Arbiter FSM states: one write path, one read path, both return to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_ADDR  = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_ADDR  = 3'd4,
    R_WAIT  = 3'd5,
    R_DONE  = 3'd6
  } state_t;

  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_MAX_CAP_RUN = 8;

endpackage

// File: rtl/capture_sram_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the external SRAM.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface capture_sram_arb_if
  import capture_sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cap_req;
  logic              cap_ack;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  logic              mcu_req;
  logic              mcu_we;
  logic              mcu_ack;
  logic [ADDR_W-1:0] mcu_addr;
  logic [DATA_W-1:0] mcu_wdata;
  logic [DATA_W-1:0] mcu_rdata;

  logic [ADDR_W-1:0] sram_ab;
  logic              sram_cs_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;

  modport slave (
    input  cap_req, cap_addr, cap_data,
    input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
    input  sram_dq_i,
    output cap_ack, mcu_ack, mcu_rdata,
    output sram_ab, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe
  );

  modport master (
    output cap_req, cap_addr, cap_data,
    output mcu_req, mcu_we, mcu_addr, mcu_wdata,
    output sram_dq_i,
    input  cap_ack, mcu_ack, mcu_rdata,
    input  sram_ab, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_oe
  );

endinterface

// File: rtl/capture_sram_arb.sv
// Arbitrates a capture write stream and an MCU read/write port onto one
// asynchronous SRAM. Capture has priority; optional fairness is enabled by
// defining CAPTURE_SRAM_ARB_FAIRNESS_EN, which lets the MCU in after
// MAX_CAP_RUN consecutive capture grants. All SRAM strobes are registered.
module capture_sram_arb
  import capture_sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int MAX_CAP_RUN = DEF_MAX_CAP_RUN
) (
  input  logic               FAB_CLK,
  input  logic               M2F_RESET_N,
  capture_sram_arb_if.slave  bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 1..15");
  end
  if (MAX_CAP_RUN < 1 || MAX_CAP_RUN > 255) begin : g_bad_run
    $error("MAX_CAP_RUN must be within 1..255");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] wait_cnt;
  logic       owner_cap;
  logic       mcu_turn;
  logic       grant_cap;
  logic       grant_mcu;

`ifdef CAPTURE_SRAM_ARB_FAIRNESS_EN
  localparam logic [7:0] RUN_LIMIT = 8'(MAX_CAP_RUN);
  logic [7:0] run_cnt;

  assign mcu_turn = bus.mcu_req && (run_cnt == RUN_LIMIT);

  // Count capture grants taken while the MCU is kept waiting.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      run_cnt <= '0;
    end else if (!bus.mcu_req || grant_mcu) begin
      run_cnt <= '0;
    end else if (grant_cap) begin
      run_cnt <= run_cnt + 8'd1;
    end
  end
`else
  assign mcu_turn = 1'b0;
`endif

  assign grant_cap = (state == IDLE) && bus.cap_req && !mcu_turn;
  assign grant_mcu = (state == IDLE) && bus.mcu_req && !grant_cap;

  // State register.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; the wait counter times both strobe phases.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_cap) begin
          next_state = W_ADDR;
        end else if (grant_mcu) begin
          next_state = bus.mcu_we ? W_ADDR : R_ADDR;
        end
      end
      W_ADDR:  next_state = W_PULSE;
      W_PULSE: if (wait_cnt == 4'd0) next_state = W_HOLD;
      W_HOLD:  next_state = IDLE;
      R_ADDR:  next_state = R_WAIT;
      R_WAIT:  if (wait_cnt == 4'd0) next_state = R_DONE;
      R_DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered SRAM strobes, latched request, acks and read data, all
  // decoded from next_state so every pin changes on a clock edge.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      wait_cnt       <= '0;
      owner_cap      <= 1'b0;
      bus.sram_ab    <= '0;
      bus.sram_dq_o  <= '0;
      bus.sram_cs_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_dq_oe <= 1'b0;
      bus.cap_ack    <= 1'b0;
      bus.mcu_ack    <= 1'b0;
      bus.mcu_rdata  <= '0;
    end else begin
      if (state == W_ADDR || state == R_ADDR) begin
        wait_cnt <= WAIT_LOAD;
      end else if (wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (grant_cap) begin
        owner_cap     <= 1'b1;
        bus.sram_ab   <= bus.cap_addr;
        bus.sram_dq_o <= bus.cap_data;
      end else if (grant_mcu) begin
        owner_cap     <= 1'b0;
        bus.sram_ab   <= bus.mcu_addr;
        bus.sram_dq_o <= bus.mcu_wdata;
      end

      bus.sram_cs_n  <= (next_state == IDLE) || (next_state == R_DONE);
      bus.sram_oe_n  <= !((next_state == R_ADDR) || (next_state == R_WAIT));
      bus.sram_we_n  <= (next_state != W_PULSE);
      bus.sram_dq_oe <= (next_state == W_ADDR) || (next_state == W_PULSE) ||
                        (next_state == W_HOLD);
      bus.cap_ack    <= (next_state == W_HOLD) && owner_cap;
      bus.mcu_ack    <= ((next_state == W_HOLD) && !owner_cap) ||
                        (next_state == R_DONE);

      if (state == R_WAIT && next_state == R_DONE) begin
        bus.mcu_rdata <= bus.sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_capture_sram_arb.sv
// Scoreboard bench for capture_sram_arb: stimulus pushes expected accesses,
// a negedge monitor models the SRAM and checks each ack against the queue.
module tb_capture_sram_arb;
  import capture_sram_pkg::*;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int WC  = 2;
  localparam int MCR = 8;

  localparam logic [1:0] K_CAP = 2'd0;
  localparam logic [1:0] K_MWR = 2'd1;
  localparam logic [1:0] K_MRD = 2'd2;

  typedef struct {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic FAB_CLK = 1'b0;
  logic M2F_RESET_N = 1'b1;

  capture_sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  capture_sram_arb #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .MAX_CAP_RUN(MCR)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .M2F_RESET_N(M2F_RESET_N),
    .bus(bus)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  exp_t          expQ[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [int];

  int            weCnt, oeCnt, csCnt;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [DW-1:0] wrData;
  logic [DW-1:0] lastRead;
  logic          sepBad, prevOe, prevDq, prevAck;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectAccess(input logic [1:0] kind, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic waitAck(input bit isCap);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge FAB_CLK);
      if (isCap ? bus.cap_ack : bus.mcu_ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ack expected ack within 200 cycles (cap=%0d)", isCap);
    end
  endtask

  task automatic applyStimulus(input bit isCap, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (isCap) begin
      bus.cap_addr = addr;
      bus.cap_data = data;
      bus.cap_req  = 1'b1;
    end else begin
      bus.mcu_addr  = addr;
      bus.mcu_we    = we;
      bus.mcu_wdata = data;
      bus.mcu_req   = 1'b1;
    end
    waitAck(isCap);
    if (isCap) bus.cap_req = 1'b0;
    else bus.mcu_req = 1'b0;
  endtask

  task automatic capStream(input int n);
    bus.cap_addr = 18'h00100;
    bus.cap_data = 16'hC000;
    bus.cap_req  = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitAck(1'b1);
      bus.cap_addr = 18'h00100 + AW'(i + 1);
      bus.cap_data = 16'hC000 + DW'(i + 1);
    end
    bus.cap_req = 1'b0;
  endtask

  task automatic scoreAck();
    exp_t e;
    checkOutput("ack_single_pulse", {31'd0, prevAck}, 32'd0);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_ack: got cap=%0d mcu=%0d expected no ack",
               bus.cap_ack, bus.mcu_ack);
      return;
    end
    e = expQ.pop_front();
    checkOutput("ack_from_capture", {31'd0, bus.cap_ack}, {31'd0, e.kind == K_CAP});
    checkOutput("ack_from_mcu", {31'd0, bus.mcu_ack}, {31'd0, e.kind != K_CAP});
    if (e.kind == K_MRD) begin
      checkOutput("rd_addr", 32'(rdAddr), 32'(e.addr));
      checkOutput("rd_data", 32'(bus.mcu_rdata), 32'(e.data));
      checkOutput("rd_oe_low_cycles", oeCnt, WC + 1);
      checkOutput("rd_cs_low_cycles", csCnt, WC + 1);
      checkOutput("rd_we_low_cycles", weCnt, 0);
      lastRead = e.data;
    end else begin
      checkOutput("wr_addr", 32'(wrAddr), 32'(e.addr));
      checkOutput("wr_data", 32'(wrData), 32'(e.data));
      checkOutput("wr_we_low_cycles", weCnt, WC);
      checkOutput("wr_cs_low_cycles", csCnt, WC + 2);
      checkOutput("wr_oe_low_cycles", oeCnt, 0);
      checkOutput("rdata_held", 32'(bus.mcu_rdata), 32'(lastRead));
    end
    checkOutput("oe_dq_separation", {31'd0, sepBad}, 32'd0);
    weCnt  = 0;
    oeCnt  = 0;
    csCnt  = 0;
    sepBad = 1'b0;
  endtask

  // Monitor and SRAM model: track strobes each cycle, score on every ack.
  always @(negedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      weCnt = 0; oeCnt = 0; csCnt = 0;
      sepBad = 1'b0; prevOe = 1'b0; prevDq = 1'b0; prevAck = 1'b0;
      lastRead = '0;
      bus.sram_dq_i = '0;
    end else begin
      if (!bus.sram_we_n) begin
        weCnt++;
        wrAddr = bus.sram_ab;
        wrData = bus.sram_dq_o;
        if (bus.sram_dq_oe && !bus.sram_cs_n) mem[int'(bus.sram_ab)] = bus.sram_dq_o;
      end
      if (!bus.sram_oe_n) begin
        oeCnt++;
        rdAddr = bus.sram_ab;
      end
      if (!bus.sram_cs_n) csCnt++;
      if (!bus.sram_oe_n && bus.sram_dq_oe) sepBad = 1'b1;
      if ((bus.sram_dq_oe && prevOe) || (!bus.sram_oe_n && prevDq)) sepBad = 1'b1;
      prevOe = !bus.sram_oe_n;
      prevDq = bus.sram_dq_oe;
      if (bus.cap_ack || bus.mcu_ack) scoreAck();
      prevAck = bus.cap_ack || bus.mcu_ack;
      if (!bus.sram_cs_n && !bus.sram_oe_n)
        bus.sram_dq_i = mem.exists(int'(bus.sram_ab)) ? mem[int'(bus.sram_ab)] : 16'hDEAD;
      else
        bus.sram_dq_i = '0;
    end
  end

  // Directed sequence covering reset, both access types, priority and fairness.
  initial begin
    bit found;
    bit ackSeen;
    bus.cap_req = 1'b0; bus.cap_addr = '0; bus.cap_data = '0;
    bus.mcu_req = 1'b0; bus.mcu_we = 1'b0; bus.mcu_addr = '0; bus.mcu_wdata = '0;
    mem[32'h3FFFF] = 16'h1234;
    #1 M2F_RESET_N = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    checkOutput("rst_cs_n", {31'd0, bus.sram_cs_n}, 32'd1);
    checkOutput("rst_oe_n", {31'd0, bus.sram_oe_n}, 32'd1);
    checkOutput("rst_we_n", {31'd0, bus.sram_we_n}, 32'd1);
    checkOutput("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    checkOutput("rst_ab", 32'(bus.sram_ab), 32'd0);
    checkOutput("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
    checkOutput("rst_cap_ack", {31'd0, bus.cap_ack}, 32'd0);
    checkOutput("rst_mcu_ack", {31'd0, bus.mcu_ack}, 32'd0);
    checkOutput("rst_rdata", 32'(bus.mcu_rdata), 32'd0);
    M2F_RESET_N = 1'b1;
    @(negedge FAB_CLK);

    $display("[TB] capture write then MCU read of top address");
    expectAccess(K_CAP, 18'h00010, 16'hA5A5);
    applyStimulus(1'b1, 1'b0, 18'h00010, 16'hA5A5);
    expectAccess(K_MRD, 18'h3FFFF, 16'h1234);
    applyStimulus(1'b0, 1'b0, 18'h3FFFF, 16'h0000);

    $display("[TB] back-to-back MCU read, write, read");
    expectAccess(K_MRD, 18'h00010, 16'hA5A5);
    applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0000);
    expectAccess(K_MWR, 18'h00020, 16'hBEEF);
    applyStimulus(1'b0, 1'b1, 18'h00020, 16'hBEEF);
    expectAccess(K_MRD, 18'h00020, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 18'h00020, 16'h0000);

    $display("[TB] simultaneous requests");
    expectAccess(K_CAP, 18'h00030, 16'h5A5A);
    expectAccess(K_MWR, 18'h00040, 16'h0F0F);
    fork
      applyStimulus(1'b1, 1'b0, 18'h00030, 16'h5A5A);
      applyStimulus(1'b0, 1'b1, 18'h00040, 16'h0F0F);
    join

    $display("[TB] continuous capture stream against waiting MCU");
`ifdef CAPTURE_SRAM_ARB_FAIRNESS_EN
    for (int i = 0; i < 8; i++) expectAccess(K_CAP, 18'h00100 + AW'(i), 16'hC000 + DW'(i));
    expectAccess(K_MRD, 18'h3FFFF, 16'h1234);
    for (int i = 8; i < 10; i++) expectAccess(K_CAP, 18'h00100 + AW'(i), 16'hC000 + DW'(i));
`else
    for (int i = 0; i < 10; i++) expectAccess(K_CAP, 18'h00100 + AW'(i), 16'hC000 + DW'(i));
    expectAccess(K_MRD, 18'h3FFFF, 16'h1234);
`endif
    fork
      capStream(10);
      applyStimulus(1'b0, 1'b0, 18'h3FFFF, 16'h0000);
    join

    $display("[TB] reset during write pulse");
    bus.cap_addr = 18'h00050;
    bus.cap_data = 16'h7777;
    bus.cap_req  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge FAB_CLK);
      if (!bus.sram_we_n) found = 1'b1;
    end
    checkOutput("reach_w_pulse", {31'd0, found}, 32'd1);
    #2 M2F_RESET_N = 1'b0;
    #1;
    checkOutput("abort_we_n", {31'd0, bus.sram_we_n}, 32'd1);
    checkOutput("abort_cs_n", {31'd0, bus.sram_cs_n}, 32'd1);
    checkOutput("abort_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    ackSeen = bus.cap_ack;
    repeat (3) begin
      @(negedge FAB_CLK);
      if (bus.cap_ack) ackSeen = 1'b1;
    end
    checkOutput("abort_no_cap_ack", {31'd0, ackSeen}, 32'd0);
    expectAccess(K_CAP, 18'h00050, 16'h7777);
    M2F_RESET_N = 1'b1;
    @(posedge FAB_CLK);
    #1;
    checkOutput("first_arb_cs_n", {31'd0, bus.sram_cs_n}, 32'd0);
    checkOutput("first_arb_ab", 32'(bus.sram_ab), 32'h00050);
    waitAck(1'b1);
    bus.cap_req = 1'b0;

    repeat (4) @(negedge FAB_CLK);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
